// File: rtl/ha2_task4_pkg.sv
// Shared types and ASCII constants for the "UCLA" keyword detector.
package ha2_task4_pkg;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        SU   = 2'd1,
        SUC  = 2'd2,
        SUCL = 2'd3
    } state_t;

    localparam logic [6:0] CH_U      = 7'h55;
    localparam logic [6:0] CH_C      = 7'h43;
    localparam logic [6:0] CH_L      = 7'h4C;
    localparam logic [6:0] CH_A      = 7'h41;
    localparam logic [6:0] FOLD_MASK = 7'h20;

    function automatic logic is_lower(input logic [6:0] ch);
        return (ch >= 7'h61) && (ch <= 7'h7A);
    endfunction

endpackage

// File: rtl/ha2_task4_ascii_upcase.sv
// Combinational ASCII case fold: lowercase letters map to uppercase when enabled.
module ascii_upcase
    import ha2_task4_pkg::*;
#(
    parameter bit CASE_INSENSITIVE = 1'b1
) (
    input  logic [6:0] i_ch,
    output logic [6:0] o_ch
);

    always_comb begin
        o_ch = i_ch;
        if (CASE_INSENSITIVE && is_lower(i_ch)) begin
            o_ch = i_ch & ~FOLD_MASK;
        end
    end

endmodule

// File: rtl/ha2_task4.sv
// Streaming "UCLA" keyword detector: one character per RDY edge, one-cycle registered flag F.
module ha2_task4
    import ha2_task4_pkg::*;
#(
    parameter bit CASE_INSENSITIVE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RDY,
    input  logic [6:0] DIN,
    output logic       F
);

    logic [6:0] w_ch;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_hit;

    ascii_upcase #(
        .CASE_INSENSITIVE(CASE_INSENSITIVE)
    ) u_upcase (
        .i_ch(DIN),
        .o_ch(w_ch)
    );

    // A 'U' restarts matching from any state, since the keyword has no self-overlap.
    always_comb begin
        w_state_next = S0;
        w_hit        = 1'b0;
        unique case (r_state)
            S0:   w_state_next = (w_ch == CH_U) ? SU : S0;
            SU:   w_state_next = (w_ch == CH_C) ? SUC : ((w_ch == CH_U) ? SU : S0);
            SUC:  w_state_next = (w_ch == CH_L) ? SUCL : ((w_ch == CH_U) ? SU : S0);
            SUCL: begin
                if (w_ch == CH_A) begin
                    w_state_next = S0;
                    w_hit        = 1'b1;
                end else if (w_ch == CH_U) begin
                    w_state_next = SU;
                end else begin
                    w_state_next = S0;
                end
            end
            default: w_state_next = S0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S0;
            F       <= 1'b0;
        end else begin
            F <= RDY && w_hit;
            if (RDY) begin
                r_state <= w_state_next;
            end
        end
    end

endmodule

// File: tb/tb_ha2_task4.sv
// Self-checking bench for ha2_task4: table vectors, hand sequences and random stimulus vs a sliding-window model.
module tb_ha2_task4;

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic [6:0] din;
    logic       f_ci;
    logic       f_cs;

    int vectors;
    int miscompares;

    logic [6:0] hist_ci[$];
    logic [6:0] hist_cs[$];

    typedef struct {
        logic       rdy;
        logic [6:0] din;
        logic       exp_ci;
        logic       exp_cs;
    } vec_t;

    vec_t tab[$];

    ha2_task4 #(.CASE_INSENSITIVE(1'b1)) dut_ci (
        .CLK(clk), .RST(rst_n), .RDY(rdy), .DIN(din), .F(f_ci)
    );

    ha2_task4 #(.CASE_INSENSITIVE(1'b0)) dut_cs (
        .CLK(clk), .RST(rst_n), .RDY(rdy), .DIN(din), .F(f_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] fold(input logic [6:0] c, input bit ci);
        if (ci && c >= 7'h61 && c <= 7'h7A) return c - 7'd32;
        return c;
    endfunction

    // Match means the last four accepted characters since reset spell UCLA.
    function automatic logic window_match(input logic [6:0] h[$]);
        if (h.size() != 4) return 1'b0;
        return h[0] == 7'h55 && h[1] == 7'h43 && h[2] == 7'h4C && h[3] == 7'h41;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: F=%0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle; expected F comes from the table when use_tab, else from the model.
    task automatic apply(input logic r, input logic [6:0] d, input bit use_tab,
                         input logic t_ci, input logic t_cs, input string name);
        logic m_ci;
        logic m_cs;
        @(negedge clk);
        rdy = r;
        din = d;
        @(posedge clk);
        m_ci = 1'b0;
        m_cs = 1'b0;
        if (r) begin
            hist_ci.push_back(fold(d, 1'b1));
            hist_cs.push_back(fold(d, 1'b0));
            if (hist_ci.size() > 4) void'(hist_ci.pop_front());
            if (hist_cs.size() > 4) void'(hist_cs.pop_front());
            m_ci = window_match(hist_ci);
            m_cs = window_match(hist_cs);
        end
        #1;
        $display("vec %s rdy=%0b din=%02h F_ci=%0b F_cs=%0b", name, r, d, f_ci, f_cs);
        check({name, "_ci"}, f_ci, use_tab ? t_ci : m_ci);
        check({name, "_cs"}, f_cs, use_tab ? t_cs : m_cs);
    endtask

    task automatic push(input logic r, input logic [6:0] d, input logic e1, input logic e0);
        vec_t v;
        v.rdy = r; v.din = d; v.exp_ci = e1; v.exp_cs = e0;
        tab.push_back(v);
    endtask

    task automatic push_str(input string s, input int hit_idx, input bit hit_cs);
        for (int i = 0; i < s.len(); i++) begin
            logic [6:0] c;
            c = s[i][6:0];
            push(1'b1, c, (i == hit_idx), (i == hit_idx) && hit_cs);
        end
    endtask

    task automatic release_reset;
        @(negedge clk);
        rst_n = 1'b1;
        hist_ci.delete();
        hist_cs.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        rdy   = 1'b0;
        din   = 7'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ci", f_ci, 1'b0);
        check("reset_cs", f_cs, 1'b0);
        release_reset();

        push_str("UCLA", 3, 1'b1);
        push(1'b0, 7'h00, 1'b0, 1'b0);
        push_str("UUCLA", 4, 1'b1);
        push_str("UCUCLA", 5, 1'b1);
        push_str("UCLXA", -1, 1'b0);
        push_str("UCLA", 3, 1'b1);
        push_str("UCLA", 3, 1'b1);
        push_str("ucla", 3, 1'b0);
        push_str("UCL", -1, 1'b0);
        push(1'b0, 7'h41, 1'b0, 1'b0);
        push(1'b0, 7'h61, 1'b0, 1'b0);
        push(1'b0, 7'h41, 1'b0, 1'b0);
        push(1'b1, 7'h41, 1'b1, 1'b1);
        push(1'b1, 7'h7F, 1'b0, 1'b0);
        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i].rdy, tab[i].din, 1'b1, tab[i].exp_ci, tab[i].exp_cs, "tab");
        end

        // Lowercase keyword with random idle gaps between characters.
        for (int rep = 0; rep < 3; rep++) begin
            logic [6:0] kw[4];
            kw[0] = 7'h75; kw[1] = 7'h63; kw[2] = 7'h6C; kw[3] = 7'h61;
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap = $urandom_range(0, 4);
                for (int g = 0; g < gap; g++) begin
                    logic [6:0] junk;
                    junk = 7'($urandom);
                    apply(1'b0, junk, 1'b0, 1'b0, 1'b0, "gap");
                end
                apply(1'b1, kw[k], 1'b1, (k == 3), 1'b0, "gapkw");
            end
        end

        // Reset asserted while F is high clears it at once.
        apply(1'b1, 7'h55, 1'b0, 1'b0, 1'b0, "rst_seq");
        apply(1'b1, 7'h43, 1'b0, 1'b0, 1'b0, "rst_seq");
        apply(1'b1, 7'h4C, 1'b0, 1'b0, 1'b0, "rst_seq");
        apply(1'b1, 7'h41, 1'b1, 1'b1, 1'b1, "rst_pend");
        #1 rst_n = 1'b0;
        #1;
        check("async_clr_ci", f_ci, 1'b0);
        check("async_clr_cs", f_cs, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_ci", f_ci, 1'b0);
        release_reset();
        apply(1'b1, 7'h43, 1'b1, 1'b0, 1'b0, "post_rst");
        apply(1'b1, 7'h4C, 1'b1, 1'b0, 1'b0, "post_rst");
        apply(1'b1, 7'h41, 1'b1, 1'b0, 1'b0, "post_rst_cla");

        // Reset in the middle of a partial match loses progress.
        apply(1'b1, 7'h55, 1'b0, 1'b0, 1'b0, "mid");
        apply(1'b1, 7'h43, 1'b0, 1'b0, 1'b0, "mid");
        apply(1'b1, 7'h4C, 1'b0, 1'b0, 1'b0, "mid");
        @(negedge clk);
        rst_n = 1'b0;
        release_reset();
        apply(1'b1, 7'h41, 1'b1, 1'b0, 1'b0, "mid_rst_a");

        // Random stream biased towards keyword letters.
        for (int n = 0; n < 600; n++) begin
            logic [6:0] c;
            logic       r;
            int         sel;
            sel = $urandom_range(0, 11);
            case (sel)
                0: c = 7'h55;  1: c = 7'h43;  2: c = 7'h4C;  3: c = 7'h41;
                4: c = 7'h75;  5: c = 7'h63;  6: c = 7'h6C;  7: c = 7'h61;
                8: c = 7'h55;  9: c = 7'h41;
                default: c = 7'($urandom);
            endcase
            r = ($urandom_range(0, 3) != 0);
            apply(r, c, 1'b0, 1'b0, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
